// File: rtl/bpm_monitor.sv
// ---------------------------------------------------------------------------
// bpm_monitor
//
// Converts the heartbeat pulse count of one measurement window into
// beats-per-minute. It also raises a single alarm bit when the heart rate
// stays outside the normal band.
//
// Ports:
//   clk          system clock, rising-edge active
//   reset        asynchronous active-low reset (0 = in reset)
//   pulse_count  pulses counted in the last window, unsigned, sampled every cycle
//   bpm          registered beats per minute, saturated at 255
//   bpm_state    registered alarm: 1 = abnormal heart rate, 0 = normal
//
// Parameters:
//   WINDOW_MULT   window count to BPM multiplier (10 s window -> x6)
//   BPM_LOW       lowest normal BPM (inclusive)
//   BPM_HIGH      highest normal BPM (inclusive)
//   ALARM_CYCLES  consecutive abnormal samples needed to raise bpm_state (>=1)
// ---------------------------------------------------------------------------
module bpm_monitor #(
   parameter int WINDOW_MULT  = 6,
   parameter int BPM_LOW      = 60,
   parameter int BPM_HIGH     = 100,
   parameter int ALARM_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] pulse_count,
   output logic [7:0] bpm,
   output logic       bpm_state
);

   // The run counter must be able to hold ALARM_CYCLES itself, because it saturates there.
   localparam int CW = (ALARM_CYCLES < 2) ? 1 : $clog2(ALARM_CYCLES + 1);

   localparam logic [15:0] MULT_W  = 16'(WINDOW_MULT);
   localparam logic [7:0]  LOW_W   = 8'(BPM_LOW);
   localparam logic [7:0]  HIGH_W  = 8'(BPM_HIGH);
   localparam logic [CW:0] ALARM_W = (CW + 1)'(ALARM_CYCLES);

   logic [15:0]   w_raw;
   logic [7:0]    w_bpm_next;
   logic          w_abnormal;
   logic [CW:0]   w_run_inc;
   logic [CW-1:0] w_run_next;
   logic          w_alarm_next;

   logic [7:0]    r_bpm;
   logic          r_bpm_state;
   logic [CW-1:0] r_run_cnt;

   // The product is formed at 16 bits, so 255 x 6 cannot wrap before saturation.
   assign w_raw      = 16'(pulse_count) * MULT_W;
   assign w_bpm_next = (w_raw > 16'd255) ? 8'd255 : w_raw[7:0];
   assign w_abnormal = (w_bpm_next < LOW_W) || (w_bpm_next > HIGH_W);

   // The run count includes the current sample. One extra bit keeps the +1 from overflowing.
   assign w_run_inc  = {1'b0, r_run_cnt} + 1'b1;

   always_comb begin
      // NOTE: a default is assigned first on every path so no latch can be inferred.
      w_run_next   = '0;
      w_alarm_next = 1'b0;
      if (w_abnormal) begin
         w_run_next   = (w_run_inc > ALARM_W) ? r_run_cnt : w_run_inc[CW-1:0];
         w_alarm_next = (w_run_inc >= ALARM_W);
      end
   end

   // NOTE: sequential state uses non-blocking assignments, so all registers update together on the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bpm       <= 8'd0;
         r_bpm_state <= 1'b0;
         r_run_cnt   <= '0;
      end else begin
         r_bpm       <= w_bpm_next;
         r_bpm_state <= w_alarm_next;
         r_run_cnt   <= w_run_next;
      end
   end

   assign bpm       = r_bpm;
   assign bpm_state = r_bpm_state;

endmodule

// File: tb/tb_bpm_monitor.sv
// ---------------------------------------------------------------------------
// tb_bpm_monitor
//
// Directed bench for bpm_monitor. It uses two instances:
//   dut   default parameters (ALARM_CYCLES = 1)
//   dut3  ALARM_CYCLES = 3, to exercise the consecutive-sample alarm
// Inputs are driven 1 time unit after a rising edge, and outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_bpm_monitor;

   logic       clk;
   logic       reset;
   logic [7:0] pulse_count;
   logic [7:0] bpm;
   logic       bpm_state;

   logic       reset3;
   logic [7:0] pulse_count3;
   logic [7:0] bpm3;
   logic       bpm_state3;

   int checks   = 0;
   int failures = 0;

   bpm_monitor dut (
      .clk         (clk),
      .reset       (reset),
      .pulse_count (pulse_count),
      .bpm         (bpm),
      .bpm_state   (bpm_state)
   );

   bpm_monitor #(.ALARM_CYCLES(3)) dut3 (
      .clk         (clk),
      .reset       (reset3),
      .pulse_count (pulse_count3),
      .bpm         (bpm3),
      .bpm_state   (bpm_state3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply one sample to the default instance and check the result one edge later.
   task automatic sample(input string tag, input logic [7:0] pc,
                         input logic [7:0] exp_bpm, input logic exp_state);
      pulse_count = pc;
      tick();
      check({tag, "_bpm"},   16'(bpm),       16'(exp_bpm));
      check({tag, "_state"}, 16'(bpm_state), 16'(exp_state));
   endtask

   initial begin
      logic [7:0]  p;
      logic [15:0] e_bpm;
      logic        e_state;

      reset        = 1'b0;
      reset3       = 1'b0;
      pulse_count  = 8'd10;
      pulse_count3 = 8'd0;
      #2;
      check("rst_bpm",   16'(bpm),       16'd0);
      check("rst_state", 16'(bpm_state), 16'd0);

      // Outputs must stay cleared while reset is low, even with the clock running.
      tick();
      tick();
      check("rst_hold_bpm",   16'(bpm),       16'd0);
      check("rst_hold_state", 16'(bpm_state), 16'd0);

      // Release reset between edges. The first edge then loads a valid pair.
      reset = 1'b1;
      tick();
      check("first_bpm",   16'(bpm),       16'd60);
      check("first_state", 16'(bpm_state), 16'd0);

      sample("p16", 8'd16, 8'd96,  1'b0);
      sample("p17", 8'd17, 8'd102, 1'b1);

      // Asynchronous reset applied mid-cycle, with no clock edge in between.
      #2;
      reset = 1'b0;
      #1;
      check("async_bpm",   16'(bpm),       16'd0);
      check("async_state", 16'(bpm_state), 16'd0);
      #1;
      reset = 1'b1;

      sample("p5",   8'd5,   8'd30,  1'b1);
      sample("p9",   8'd9,   8'd54,  1'b1);
      sample("p0",   8'd0,   8'd0,   1'b1);
      sample("p1",   8'd1,   8'd6,   1'b1);
      sample("p50",  8'd50,  8'd255, 1'b1);
      sample("p255", 8'd255, 8'd255, 1'b1);
      sample("p42",  8'd42,  8'd252, 1'b1);
      sample("p43",  8'd43,  8'd255, 1'b1);
      sample("p12",  8'd12,  8'd72,  1'b0);

      // Random cases in 5..25, with a reset pulse before each case.
      for (int i = 0; i < 35; i++) begin
         p       = 8'($urandom_range(25, 5));
         e_bpm   = 16'(p) * 16'd6;
         e_state = (e_bpm < 16'd60) || (e_bpm > 16'd100);
         pulse_count = p;
         #1;
         reset = 1'b0;
         #2;
         reset = 1'b1;
         tick();
         check($sformatf("rnd%0d_bpm", i),   16'(bpm),       e_bpm);
         check($sformatf("rnd%0d_state", i), 16'(bpm_state), 16'(e_state));
      end

      // ALARM_CYCLES = 3: the alarm rises on the 3rd abnormal edge and clears on the first normal one.
      pulse_count3 = 8'd5;
      reset3       = 1'b1;
      tick();
      check("a3_e1_bpm",   16'(bpm3),       16'd30);
      check("a3_e1_state", 16'(bpm_state3), 16'd0);
      tick();
      check("a3_e2_state", 16'(bpm_state3), 16'd0);
      tick();
      check("a3_e3_state", 16'(bpm_state3), 16'd1);
      tick();
      check("a3_e4_state", 16'(bpm_state3), 16'd1);
      pulse_count3 = 8'd12;
      tick();
      check("a3_clr_bpm",   16'(bpm3),       16'd72);
      check("a3_clr_state", 16'(bpm_state3), 16'd0);

      // A single normal sample restarts the run count.
      pulse_count3 = 8'd20;
      tick();
      check("a3_r1_state", 16'(bpm_state3), 16'd0);
      tick();
      check("a3_r2_state", 16'(bpm_state3), 16'd0);
      pulse_count3 = 8'd15;
      tick();
      check("a3_brk_state", 16'(bpm_state3), 16'd0);
      pulse_count3 = 8'd20;
      tick();
      tick();
      check("a3_r2b_state", 16'(bpm_state3), 16'd0);

      // Reset in the middle of a run also restarts the count from 0.
      #1;
      reset3 = 1'b0;
      #2;
      reset3 = 1'b1;
      tick();
      check("a3_rst1_state", 16'(bpm_state3), 16'd0);
      tick();
      check("a3_rst2_state", 16'(bpm_state3), 16'd0);
      tick();
      check("a3_rst3_state", 16'(bpm_state3), 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
